// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream boot loader that fills IMEM and releases core reset
// Frame: SYNC, LEN_LO, LEN_HI, 4*N little-endian payload bytes, XOR checksum byte.
module imem_boot_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t          state;
    logic [15:0]     len;
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_buf;
    logic [7:0]      acc;

    logic            take;
    logic [15:0]     n_next;
    logic [16:0]     idx_inc;

    assign take    = in_valid & in_ready;
    assign n_next  = {in_data, len[7:0]};
    assign idx_inc = 17'(word_idx) + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            acc        <= '0;
        end else begin
            imem_we  <= 1'b0;
            // Terminal-state entry below overrides this to drop ready on the same edge.
            in_ready <= (state != DONE) && (state != ERROR);
            if (take) begin
                case (state)
                    IDLE: begin
                        if (in_data == SYNC) state <= LEN_LO;
                    end
                    LEN_LO: begin
                        len[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        len[15:8] <= in_data;
                        if ({1'b0, n_next} > DEPTH) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (n_next == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        acc      <= acc ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {in_data, word_buf};
                                imem_addr  <= word_idx[ADDR_W-1:0];
                                word_idx   <= word_idx + (ADDR_W+1)'(1);
                                if (idx_inc == {1'b0, len}) state <= CSUM;
                            end
                        endcase
                    end
                    CSUM: begin
                        in_ready <= 1'b0;
                        if (in_data == acc) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
